clk_sel_ctrl: RTL and testbench
===============================

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_CLK, default 4, giving the number of selectable clock sources; legal range 2..16.
REQ-002 The module SHALL have parameter OFF_CYCLES, default 4, giving the clk cycles all enables stay low during a switch; legal range 1..255.
REQ-003 The module SHALL have parameter DEFAULT_SEL, default 0, giving the source enabled out of reset; legal range 0..NUM_CLK-1.
REQ-004 The module SHALL derive SEL_W = max(1, clog2(NUM_CLK)) as a localparam.
REQ-005 Port clk: input, 1 bit; the single clock, with all logic on its rising edge.
REQ-006 Port rst: input, 1 bit; asynchronous reset, active-high.
REQ-007 Port req_valid: input, 1 bit; a switch request is present.
REQ-008 Port req_sel: input, SEL_W bits; the requested source index.
REQ-009 Port req_ready: output, 1 bit; the controller can accept a request.
REQ-010 Port clk_en: output, NUM_CLK bits; per-source gate enables, one-hot or all-zero.
REQ-011 Port cur_sel: output, SEL_W bits; the currently enabled source index.
REQ-012 Port busy: output, 1 bit; a switch is in progress.
REQ-013 Port done: output, 1 bit; one-cycle pulse when a request completes.
REQ-014 Port err: output, 1 bit; one-cycle pulse when a request is rejected.
REQ-015 Port switch_cnt: output, 8 bits; saturating count of completed real switches.

Function
REQ-016 The FSM SHALL have exactly two states:
  - IDLE
  - GAP
REQ-017 req_ready SHALL be 1 in IDLE and 0 in GAP; busy SHALL be the inverse of req_ready.
REQ-018 A request SHALL be accepted only on a rising clk edge with req_valid=1 and req_ready=1; req_valid while busy SHALL be ignored, with no queueing.
REQ-019 An accepted request with req_sel >= NUM_CLK SHALL pulse err for one cycle and leave state, clk_en, cur_sel and switch_cnt unchanged.
REQ-020 An accepted request with req_sel == cur_sel SHALL pulse done in the next cycle, stay in IDLE, and leave clk_en and switch_cnt unchanged.
REQ-021 An accepted valid request with req_sel != cur_sel SHALL latch req_sel as the target, and in the next cycle:
  - drive clk_en to all-zero
  - enter GAP
  - load the down-counter with OFF_CYCLES-1
REQ-022 In GAP the counter SHALL decrement each cycle; while the counter is nonzero, clk_en SHALL stay all-zero.
REQ-023 On the GAP cycle with counter == 0, the next edge SHALL:
  - set clk_en to one-hot(target)
  - set cur_sel = target
  - pulse done
  - increment switch_cnt, saturating at 255
  - return to IDLE
REQ-024 Switch latency SHALL be as follows, with acceptance at edge T:
  - clk_en is all-zero from T+1 through T+OFF_CYCLES inclusive (exactly OFF_CYCLES cycles)
  - the new enable and done are high from T+1+OFF_CYCLES
REQ-025 req_ready SHALL be 1 again in the cycle done is high, so back-to-back requests are accepted with no extra idle cycle.
REQ-026 clk_en SHALL never have more than one bit set, in any cycle, including the reset-release cycle.
REQ-027 done and err SHALL never be high in the same cycle.
REQ-028 done and err SHALL each be exactly one cycle wide.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to clk_en.

Reset
REQ-030 While rst=1, the outputs SHALL take these values:
  - clk_en = one-hot(DEFAULT_SEL)
  - cur_sel = DEFAULT_SEL
  - state = IDLE, counter = 0
  - req_ready = 1, busy = 0
  - done = 0, err = 0
  - switch_cnt = 0
REQ-031 Reset asserted during GAP SHALL abort the switch immediately, without waiting for clk, and restore the REQ-030 values; the latched target SHALL be discarded.
REQ-032 Reset deassertion SHALL take effect on the next rising clk edge; no request is accepted on that edge unless rst is already low at it.

Verification
REQ-033 Reset, then NUM_CLK=4, OFF_CYCLES=4, request sel=2 -> clk_en=0000 for 4 cycles, then 0100, cur_sel=2, done pulse, switch_cnt=1.
REQ-034 Request sel equal to cur_sel -> done pulse next cycle, clk_en unchanged, switch_cnt unchanged, busy never high.
REQ-035 NUM_CLK=3, request sel=3 -> err pulse, no done, clk_en unchanged; a request held during GAP -> ignored, with only one done.
REQ-036 Assert rst mid-GAP after 2 cycles -> clk_en=0001 (DEFAULT_SEL=0) asynchronously, busy=0; after release, a new request completes normally.
REQ-037 Run 300 back-to-back alternating requests 1/0 -> each switch takes exactly OFF_CYCLES gap cycles, switch_cnt saturates at 255, and an assertion confirms clk_en is never multi-hot.

Source files
------------

// File: rtl/clk_sel_ctrl.sv
// Glitch-free clock source selector: drops all gate enables for OFF_CYCLES clk cycles
// before enabling the newly requested source. Outputs registered; requests ignored while busy.
module clk_sel_ctrl #(
    parameter int NUM_CLK     = 4,
    parameter int OFF_CYCLES  = 4,
    parameter int DEFAULT_SEL = 0,
    localparam int SEL_W      = (NUM_CLK > 2) ? $clog2(NUM_CLK) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    output logic [NUM_CLK-1:0] clk_en,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         switch_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam logic [SEL_W:0]     NUM_CLK_W = (SEL_W + 1)'(NUM_CLK);
    localparam logic [SEL_W-1:0]   DEF_SEL   = SEL_W'(DEFAULT_SEL);
    localparam logic [NUM_CLK-1:0] DEF_EN    = NUM_CLK'(1) << DEFAULT_SEL;
    localparam logic [7:0]         GAP_LOAD  = 8'(OFF_CYCLES - 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_CLK-1:0] en_q, en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         swc_q, swc_d;

    function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_CLK'(1) << idx;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        swc_d   = swc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if ({1'b0, req_sel} >= NUM_CLK_W) begin
                        err_d = 1'b1;
                    end else if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = req_sel;
                        en_d    = '0;
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Gap has elapsed: the new source can be gated on safely.
                    en_d    = onehot(tgt_q);
                    sel_d   = tgt_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (swc_q != 8'hFF) begin
                        swc_d = swc_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            tgt_q   <= DEF_SEL;
            sel_q   <= DEF_SEL;
            en_q    <= DEF_EN;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            swc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            swc_q   <= swc_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q == GAP);
    assign clk_en     = en_q;
    assign cur_sel    = sel_q;
    assign done       = done_q;
    assign err        = err_q;
    assign switch_cnt = swc_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed and randomized checks of clk_sel_ctrl against a transaction-level model.
module tb_clk_sel_ctrl;

    localparam int NC  = 4;
    localparam int OFF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_ready, busy, done, err;
    logic [3:0] clk_en;
    logic [1:0] cur_sel;
    logic [7:0] switch_cnt;

    logic       req_valid3 = 1'b0;
    logic [1:0] req_sel3 = 2'd0;
    logic       req_ready3, busy3, done3, err3;
    logic [2:0] clk_en3;
    logic [1:0] cur_sel3;
    logic [7:0] switch_cnt3;

    int checks = 0;
    int failures = 0;
    int m_sel = 0;
    int m_cnt = 0;

    clk_sel_ctrl #(.NUM_CLK(NC), .OFF_CYCLES(OFF), .DEFAULT_SEL(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .clk_en(clk_en), .cur_sel(cur_sel), .busy(busy),
        .done(done), .err(err), .switch_cnt(switch_cnt)
    );

    clk_sel_ctrl #(.NUM_CLK(3), .OFF_CYCLES(OFF), .DEFAULT_SEL(0)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_sel(req_sel3),
        .req_ready(req_ready3), .clk_en(clk_en3), .cur_sel(cur_sel3), .busy(busy3),
        .done(done3), .err(err3), .switch_cnt(switch_cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh4(input int i);
        return 4'(2 ** i);
    endfunction

    always @(negedge clk) begin
        chk("not_multi_hot", 32'(($countones(clk_en) <= 1) && ($countones(clk_en3) <= 1)), 1);
        chk("done_err_excl", 32'((done && err) || (done3 && err3)), 0);
    end

    // One request from an idle negedge; returns at the negedge of the done cycle.
    task automatic do_req(input int sel, input bit hold);
        req_valid = 1'b1;
        req_sel   = 2'(sel);
        @(negedge clk);
        if (sel == m_sel) begin
            req_valid = 1'b0;
            chk("same_done", done, 1);
            chk("same_en", clk_en, oh4(m_sel));
            chk("same_busy", busy, 0);
            chk("same_cnt", switch_cnt, m_cnt);
        end else begin
            if (hold) req_sel = 2'(3 - sel);
            else req_valid = 1'b0;
            for (int k = 1; k <= OFF; k++) begin
                if (k > 1) @(negedge clk);
                chk("gap_en", clk_en, 0);
                chk("gap_busy", busy, 1);
                chk("gap_done", done, 0);
            end
            req_valid = 1'b0;
            @(negedge clk);
            m_sel = sel;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            chk("sw_en", clk_en, oh4(m_sel));
            chk("sw_sel", cur_sel, m_sel);
            chk("sw_done", done, 1);
            chk("sw_ready", req_ready, 1);
            chk("sw_cnt", switch_cnt, m_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_en", clk_en, 4'b0001);
        chk("rst_sel", cur_sel, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_cnt", switch_cnt, 0);
        chk("rst_en3", clk_en3, 3'b001);
        rst = 1'b0;
        @(negedge clk);

        do_req(2, 1'b0);
        @(negedge clk);
        chk("done_width", done, 0);

        do_req(2, 1'b0);
        @(negedge clk);
        chk("same_done_width", done, 0);
        chk("same_busy_after", busy, 0);

        do_req(1, 1'b1);
        @(negedge clk);
        chk("held_no_second_done", done, 0);
        chk("held_idle", busy, 0);
        chk("held_sel", cur_sel, 1);

        req_valid3 = 1'b1;
        req_sel3   = 2'd3;
        @(negedge clk);
        req_valid3 = 1'b0;
        chk("err_pulse", err3, 1);
        chk("err_no_done", done3, 0);
        chk("err_en", clk_en3, 3'b001);
        chk("err_ready", req_ready3, 1);
        chk("err_cnt", switch_cnt3, 0);
        @(negedge clk);
        chk("err_width", err3, 0);
        req_valid3 = 1'b1;
        req_sel3   = 2'd2;
        @(negedge clk);
        req_valid3 = 1'b0;
        for (int k = 1; k <= OFF; k++) begin
            if (k > 1) @(negedge clk);
            chk("gap_en3", clk_en3, 0);
        end
        @(negedge clk);
        chk("sw_en3", clk_en3, 3'b100);
        chk("sw_sel3", cur_sel3, 2);
        chk("sw_done3", done3, 1);

        req_valid = 1'b1;
        req_sel   = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_gap_en", clk_en, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_en", clk_en, 4'b0001);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_sel", cur_sel, 0);
        chk("async_rst_cnt", switch_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        m_sel = 0;
        m_cnt = 0;
        @(negedge clk);
        chk("post_rst_en", clk_en, 4'b0001);
        do_req(3, 1'b0);

        repeat (40) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)));
        end

        do_req(0, 1'b0);
        for (int i = 0; i < 300; i++) do_req((i % 2 == 0) ? 1 : 0, 1'b0);
        chk("saturated", switch_cnt, 255);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
